// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: operation codes, alu_op encodings, FSM state codes and latency classes for the ALU control stage
package alu_ctrl_pkg;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110, OP_SLL = 4'b0111, OP_SRL = 4'b1000, OP_SRA = 4'b1001;
  localparam logic [3:0] OP_SLT = 4'b1010, OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100, OP_DIV = 4'b1101, OP_REM = 4'b1110;
  localparam logic [1:0] ALUOP_MEM = 2'b00, ALUOP_BR = 2'b01, ALUOP_R = 2'b10;
  localparam logic [1:0] ST_EMPTY = 2'b00, ST_HOLD = 2'b01, ST_MULTI = 2'b10;
  typedef enum logic [1:0] {LAT_NONE, LAT_MUL, LAT_DIV} lat_e;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
  function automatic logic [3:0] r_op(input logic [2:0] f3, input logic b5);
    case (f3)
      3'b000: r_op = b5 ? OP_SUB : OP_ADD;
      3'b001: r_op = OP_SLL;
      3'b010: r_op = OP_SLT;
      3'b011: r_op = OP_SLTU;
      3'b100: r_op = OP_XOR;
      3'b101: r_op = b5 ? OP_SRA : OP_SRL;
      3'b110: r_op = OP_OR;
      default: r_op = OP_AND;
    endcase
  endfunction
  function automatic logic [3:0] m_op(input logic [2:0] f3);
    return f3 == 3'b000 ? OP_MUL : f3 == 3'b100 ? OP_DIV : OP_REM;
  endfunction
endpackage

// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: ID-side and EX-side handshake bundle of the ALU control stage
interface alu_ctrl_if #(parameter int OP_W = 4);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic            funct7_b5;
  logic            funct7_b0;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] out_op;
  logic            out_illegal;
  logic            out_busy;
  modport master (
    output in_valid, alu_op, funct3, funct7_b5, funct7_b0, out_ready,
    input  in_ready, out_valid, out_op, out_illegal, out_busy
  );
  modport slave (
    input  in_valid, alu_op, funct3, funct7_b5, funct7_b0, out_ready,
    output in_ready, out_valid, out_op, out_illegal, out_busy
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational ALUOp/funct decode to op code, illegal flag and latency class; M-extension decode under ALU_CTRL_MEXT_EN
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  input  logic       funct7_b0,
  output logic [3:0] op,
  output logic       illegal,
  output lat_e       lat
);
  // every illegal path falls back to ADD so op is never left undriven
  always_comb begin
    op = OP_ADD;
    illegal = 1'b0;
    lat = LAT_NONE;
    case (alu_op)
      ALUOP_MEM: op = funct3 == 3'b001 ? OP_SLL : funct3 == 3'b101 ? (funct7_b5 ? OP_SRA : OP_SRL) : OP_ADD;
      ALUOP_BR: begin
        illegal = funct3[2:1] == 2'b01;
        op = illegal ? OP_ADD : OP_SUB;
      end
      ALUOP_R:
        if (funct7_b0) begin
`ifdef ALU_CTRL_MEXT_EN
          illegal = !(funct3 inside {3'b000, 3'b100, 3'b110});
          op = illegal ? OP_ADD : m_op(funct3);
          lat = illegal ? LAT_NONE : funct3 == 3'b000 ? LAT_MUL : LAT_DIV;
`else
          illegal = 1'b1;
`endif
        end else begin
          illegal = funct7_b5 && !(funct3 inside {3'b000, 3'b101});
          op = illegal ? OP_ADD : r_op(funct3, funct7_b5);
        end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: registered ALU control slot between ID and EX with valid/ready handshake; ALU_CTRL_MEXT_EN adds M-extension decode and busy countdown
module alu_ctrl_stage
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 16
) (
  input logic       clk,
  input logic       rst_n,
  input logic       flush,
  alu_ctrl_if.slave bus
);
  logic [1:0] state_d, state_q;
  logic [3:0] op_d, op_q, dec_op;
  logic       ill_d, ill_q, dec_ill;
  lat_e       dec_lat;
  logic       accept, retire, load_multi, multi_done;

  alu_ctrl_decode u_dec (
    .alu_op    (bus.alu_op),
    .funct3    (bus.funct3),
    .funct7_b5 (bus.funct7_b5),
    .funct7_b0 (bus.funct7_b0),
    .op        (dec_op),
    .illegal   (dec_ill),
    .lat       (dec_lat)
  );

  assign bus.out_valid   = state_q != ST_EMPTY;
  assign bus.out_op      = OP_W'(op_q);
  assign bus.out_illegal = ill_q;
  assign bus.in_ready    = !flush && (state_q == ST_EMPTY || (state_q == ST_HOLD && bus.out_ready));
  assign accept          = bus.in_valid && bus.in_ready;
  assign retire          = state_q == ST_HOLD && bus.out_ready;

`ifdef ALU_CTRL_MEXT_EN
  localparam int CNT_W = $clog2(max_int(MUL_LAT, DIV_LAT) + 1);
  logic [CNT_W-1:0] cnt_d, cnt_q, cnt_load;
  assign cnt_load     = dec_lat == LAT_MUL ? CNT_W'(MUL_LAT - 1) : dec_lat == LAT_DIV ? CNT_W'(DIV_LAT - 1) : '0;
  assign load_multi   = cnt_load != '0;
  assign multi_done   = cnt_q == CNT_W'(1);
  assign bus.out_busy = state_q == ST_MULTI;
  // countdown: loaded on accept, cleared by flush, otherwise steps toward zero
  always_comb begin
    cnt_d = flush ? '0 : accept ? cnt_load : cnt_q == '0 ? '0 : cnt_q - CNT_W'(1);
  end
  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  logic unused_lat;
  assign unused_lat   = ^{dec_lat} ^ (MUL_LAT + DIV_LAT > 0);
  assign load_multi   = 1'b0;
  assign multi_done   = 1'b1;
  assign bus.out_busy = 1'b0;
`endif

  // flush beats everything; accept in HOLD doubles as the same-cycle retire
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    ill_d = ill_q;
    if (flush) state_d = ST_EMPTY;
    else if (accept) begin
      state_d = load_multi ? ST_MULTI : ST_HOLD;
      op_d = dec_op;
      ill_d = dec_ill;
    end else if (retire) state_d = ST_EMPTY;
    else if (state_q == ST_MULTI && multi_done) state_d = ST_HOLD;
  end

  // slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      op_q <= '0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      ill_q <= ill_d;
    end
  end
endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb_alu_ctrl_stage: directed scoreboard bench for alu_ctrl_stage (adapts to ALU_CTRL_MEXT_EN)
module tb_alu_ctrl_stage;
  localparam int OP_W = 4, MUL_LAT = 3, DIV_LAT = 16;
`ifdef ALU_CTRL_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif
  localparam logic [4:0] EXP_MUL = MEXT ? 5'b0_1100 : 5'b1_0010;
  localparam logic [4:0] EXP_DIV = MEXT ? 5'b0_1101 : 5'b1_0010;
  localparam logic [4:0] EXP_REM = MEXT ? 5'b0_1110 : 5'b1_0010;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  always #5 clk = ~clk;

  alu_ctrl_if #(.OP_W(OP_W)) bus ();
  alu_ctrl_stage #(.OP_W(OP_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int total = 0, bad = 0;
  logic [4:0] exp_q [$];

  // {alu_op, funct3, funct7_b5, funct7_b0, illegal, op}
  logic [11:0] vecs [21] = '{
    12'b10_000_0_0_00010, 12'b10_000_1_0_00110, 12'b10_101_1_0_01001, 12'b10_111_0_0_00000,
    12'b10_001_0_0_00111, 12'b10_010_0_0_01010, 12'b10_011_0_0_01011, 12'b10_100_0_0_00011,
    12'b10_101_0_0_01000, 12'b10_110_0_0_00001, 12'b00_001_0_0_00111, 12'b00_101_1_0_01001,
    12'b00_101_0_0_01000, 12'b00_010_0_0_00010, 12'b01_000_0_0_00110, 12'b01_111_0_0_00110,
    12'b01_010_0_0_10010, 12'b01_011_0_0_10010, 12'b11_000_0_0_10010, 12'b10_001_1_0_10010,
    12'b10_010_0_1_10010
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // monitor: every retirement is compared against the oldest expected op
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready && !bus.out_busy) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL retire_unexpected: got op %0h with nothing expected", bus.out_op);
      end else check("retire", {27'd0, bus.out_illegal, bus.out_op}, {27'd0, exp_q.pop_front()});
    end
  end

  task automatic send(input logic [11:0] v, output int stall);
    stall = 0;
    bus.in_valid = 1'b1;
    {bus.alu_op, bus.funct3, bus.funct7_b5, bus.funct7_b0} = v[11:5];
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      stall++;
      if (stall > 60) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, want 1", stall);
        break;
      end
      @(posedge clk); #1;
    end
    if (bus.in_ready) exp_q.push_back(v[4:0]);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic measure(output int v, output int b, output int r);
    v = 0; b = 0; r = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!bus.out_valid) return;
      v++;
      b += int'(bus.out_busy);
      r += int'(!bus.in_ready);
      @(posedge clk); #1;
    end
    total++;
    bad++;
    $display("FAIL measure_timeout: still valid after %0d cycles, want release", v);
  endtask

  initial begin
    int st, sum, v, b, r;
    bus.in_valid = 1'b0; bus.alu_op = '0; bus.funct3 = '0;
    bus.funct7_b5 = 1'b0; bus.funct7_b0 = 1'b0; bus.out_ready = 1'b0;
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_op", bus.out_op, 0);
    check("rst_out_illegal", bus.out_illegal, 0);
    check("rst_out_busy", bus.out_busy, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    sum = 0;
    foreach (vecs[i]) begin
      send(vecs[i], st);
      sum += st;
    end
    check("stream_stall", sum, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(12'b10_100_0_0_00011, st);
    @(negedge clk);
    check("latency_valid", bus.out_valid, 1);
    check("hold_op", bus.out_op, 4'b0011);
    check("hold_in_ready", bus.in_ready, 0);
    @(posedge clk); @(negedge clk);
    check("stable_op", bus.out_op, 4'b0011);
    check("stable_illegal", bus.out_illegal, 0);
    @(posedge clk); #1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    send({2'b10, 3'b000, 1'b0, 1'b1, EXP_MUL}, st);
    measure(v, b, r);
    check("mul_valid_cycles", v, MEXT ? MUL_LAT : 1);
    check("mul_busy_cycles", b, MEXT ? MUL_LAT - 1 : 0);
    check("mul_ready_low", r, MEXT ? MUL_LAT - 1 : 0);
    @(posedge clk); #1;
    send({2'b10, 3'b110, 1'b0, 1'b1, EXP_REM}, st);
    measure(v, b, r);
    check("rem_valid_cycles", v, MEXT ? DIV_LAT : 1);
    check("rem_busy_cycles", b, MEXT ? DIV_LAT - 1 : 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send({2'b10, 3'b100, 1'b0, 1'b1, EXP_DIV}, st);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    bus.in_valid = 1'b1; bus.alu_op = 2'b00; bus.funct3 = 3'b000; bus.funct7_b0 = 1'b0;
    @(negedge clk); check("flush_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("flush_valid", bus.out_valid, 0);
    check("flush_busy", bus.out_busy, 0);
    check("flush_in_ready_after", bus.in_ready, 1);
`ifdef ALU_CTRL_MEXT_EN
    check("flush_count", dut.cnt_q, 0);
`endif
    @(posedge clk); #1;
    send(12'b00_000_0_0_00010, st);
    check("post_flush_stall", st, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send({2'b10, 3'b100, 1'b0, 1'b1, EXP_DIV}, st);
    repeat (5) @(posedge clk);
    #1;
`ifdef ALU_CTRL_MEXT_EN
    check("count_before_rst", dut.cnt_q, 10);
`endif
    check("valid_before_rst", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_op", bus.out_op, 0);
    check("midrst_illegal", bus.out_illegal, 0);
    check("midrst_busy", bus.out_busy, 0);
`ifdef ALU_CTRL_MEXT_EN
    check("midrst_count", dut.cnt_q, 0);
`endif
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_valid_after", bus.out_valid, 0);
    check("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Registered, parametrised successor to the combinational ALU control decoder, sitting between ID and EX in the pipelined RISC-V core. It decodes ALUOp/funct fields into an ALU operation code and holds it in an output slot with valid/ready handshakes. Optionally, it tracks multi-cycle M-extension operations with a busy countdown that back-pressures ID. All undefined encodings are flagged as illegal; none leave the operation undriven.

## Interface
- `OP_W`, 4: operation code width, minimum 4.
- `MUL_LAT`, 3: total EX cycles for MUL, range 1..15.
- `DIV_LAT`, 16: total EX cycles for DIV/REM, range 1..63.
- `clk`  in  1  single clock domain; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous; kills the held op and aborts any countdown.
- `in_valid`  in  1  ID presents a decoded instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `alu_op`  in  2  00 = load/store/I-type, 01 = branch, 10 = R-type, 11 = reserved.
- `funct3`  in  3  instruction funct3.
- `funct7_b5`  in  1  instruction bit 30.
- `funct7_b0`  in  1  instruction bit 25, the M-extension selector.
- `out_valid`  out  1  `out_op` holds a live operation.
- `out_ready`  in  1  EX can take the op.
- `out_op`  out  OP_W  operation code, zero-extended.
- `out_illegal`  out  1  held op decoded from an illegal encoding.
- `out_busy`  out  1  multi-cycle op still counting; EX must hold.

## Operation
- Operation codes (4 LSBs):
  - AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLL 0111.
  - SRL 1000, SRA 1001, SLT 1010, SLTU 1011.
  - MUL 1100, DIV 1101, REM 1110.
- alu_op 00: funct3 001 → SLL; 101 → SRL, or SRA when funct7_b5 = 1; all other funct3 → ADD.
- alu_op 01: funct3 000/001/100/101/110/111 → SUB. funct3 010/011 → illegal.
- alu_op 10, funct7_b0 = 0: the funct3 and funct7_b5 pair selects ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR or AND. funct7_b5 = 1 with funct3 ∉ {000, 101} → illegal.
- alu_op 10, funct7_b0 = 1: funct3 000 → MUL; 100 → DIV; 110 → REM; any other funct3 → illegal.
- alu_op 11 → illegal.
- An illegal op sets `out_op` = ADD and `out_illegal` = 1, and is passed downstream as a normal single-cycle op.
- State machine:
  - EMPTY: `out_valid` = 0.
  - HOLD: valid, count = 0.
  - MULTI: valid, count > 0.
- Accept: when `in_valid && in_ready`, the decode is captured. MUL loads the count with MUL_LAT-1; DIV/REM load DIV_LAT-1. The next state is MULTI if the loaded count is > 0, otherwise HOLD.
- MULTI: count decrements each cycle and moves to HOLD on reaching 0. `out_busy` = (state == MULTI).
- Retire: `out_valid && out_ready && !out_busy` releases the slot.
- `in_ready` = EMPTY, or HOLD with `out_ready` = 1 (back-to-back refill in the same cycle).
- Priority, highest first: reset, flush, retire/accept. On flush the state goes to EMPTY, the count to 0, and `in_valid` is ignored that cycle; `in_ready` is 0 during flush.
- The count width is derived from max(MUL_LAT, DIV_LAT).

## Timing
- Reset values: `out_valid` 0, `out_op` 0, `out_illegal` 0, `out_busy` 0, count 0, state EMPTY. `in_ready` = 1 once reset is released.
- Reset asserted mid-countdown clears all state immediately, with no edge required.
- Latency: accept at edge N → `out_valid` at N+1.
- Throughput: single-cycle ops sustain 1 op/cycle.
- A MUL op occupies the slot MUL_LAT cycles minimum; a DIV/REM op occupies DIV_LAT cycles minimum.
- `out_op` and `out_illegal` are stable while `out_valid` = 1 and the op has not retired.
- `in_ready` is combinational from `out_ready`, the state and `flush`; it has no path from `in_valid`.

## Configuration
- `ALU_CTRL_MEXT_EN` defined: MUL/DIV/REM decode and the countdown logic are present.
- `ALU_CTRL_MEXT_EN` undefined:
  - Any alu_op 10 with funct7_b0 = 1 → illegal (ADD, `out_illegal` = 1).
  - `out_busy` is tied to 0 and no counter is instantiated.
  - MUL_LAT and DIV_LAT are ignored.

## Structure
- `alu_ctrl_pkg` holds the operation-code constants, the alu_op encodings and the state enum.
- Sub-module `alu_ctrl_decode` is the pure combinational decode, outputting op code, illegal flag and multi-cycle latency select.
- `alu_ctrl_stage` owns the registers, FSM, counter and handshake.

## Test plan
- Reset asserted during MULTI (count 10): all outputs 0 immediately; `in_ready` = 1 after release.
- Stream R-type ADD, SUB, SRA, AND with `out_ready` held 1 → codes 0010, 0110, 1001, 0000 on consecutive cycles; `in_ready` stays 1.
- MUL with MUL_LAT = 3 and `out_ready` = 1 → `out_busy` high 2 cycles; `in_ready` low 2 cycles; retires on the 3rd valid cycle.
- DIV accepted, then `flush` 4 cycles later → `out_valid` 0 next cycle; count 0; new ADD accepted the cycle after.
- alu_op 01/funct3 010, alu_op 11, and alu_op 10/funct3 001/funct7_b5 = 1 → each gives `out_op` 0010, `out_illegal` 1.
- Build without `ALU_CTRL_MEXT_EN`: R-type with funct7_b0 = 1 → illegal, `out_busy` never asserted.
